// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch initiator.
// Owns the fetch PC and issues sequential word fetches to imem.
// The number of fetches in flight is limited by credits.
// Each returned instruction is tagged with its PC and pushed into a small fetch queue toward decode.
// A redirect discards every response still in flight, without stalling the imem handshake.
// Optional feature macro: IFETCH_STATS_EN adds the stat_drop_cnt output, a count of discarded responses.

module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          FQ_DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] stat_drop_cnt
`endif
);

    // The counter width covers outstanding + fq_count, so the credit sum cannot overflow.
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + FQ_DEPTH + 1);
    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_OUT_C  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] FQ_DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO_C = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(FQ_DEPTH - 1);

    // Queue pointers wrap at FQ_DEPTH, so a depth that is not a power of two also works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST_C) begin
            nxt = PTR_ZERO_C;
        end else begin
            nxt = ptr + PTR_ONE_C;
        end
        return nxt;
    endfunction

    logic [31:0]      fetch_pc_r;
    logic [31:0]      resp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] fq_count_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [31:0]      pc_mem_r   [FQ_DEPTH];
    logic [31:0]      inst_mem_r [FQ_DEPTH];

    logic [CNT_W-1:0] credit_sum_s;
    logic [CNT_W-1:0] resp_fire_ext_s;
    logic [31:0]      redirect_tgt_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             resp_fire_s;
    logic             drop_s;
    logic             push_s;
    logic             pop_s;

    // Masking the address, rather than slicing it, keeps every bit of redirect_pc in use.
    assign redirect_tgt_s  = redirect_pc & 32'hFFFF_FFFC;
    assign credit_sum_s    = outstanding_r + fq_count_r;
    assign resp_fire_ext_s = {{(CNT_W-1){1'b0}}, resp_fire_s};

    // Issue rule: a request may go out only if a queue slot is reserved for every fetch in flight.
    always_comb begin
        req_valid_s = 1'b0;
        if (!rst_n) begin
            req_valid_s = 1'b0;
        end else if (redirect_valid) begin
            req_valid_s = 1'b0;
        end else if ((outstanding_r < MAX_OUT_C) && (credit_sum_s < FQ_DEPTH_C)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // Handshake decode: classify the incoming response as dropped or pushed, and qualify the pop.
    always_comb begin
        req_fire_s  = req_valid_s && imem_req_ready;
        resp_fire_s = imem_resp_valid;
        drop_s      = 1'b0;
        push_s      = 1'b0;
        if (resp_fire_s) begin
            if (redirect_valid || (drop_cnt_r != CNT_ZERO_C)) begin
                drop_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            drop_s = 1'b0;
            push_s = 1'b0;
        end
        pop_s = (fq_count_r != CNT_ZERO_C) && out_ready && !redirect_valid;
    end

    assign imem_req_valid  = req_valid_s;
    assign imem_req_addr   = fetch_pc_r;
    assign imem_resp_ready = 1'b1;
    assign out_valid       = (fq_count_r != CNT_ZERO_C);
    assign out_pc          = pc_mem_r[head_r];
    assign out_inst        = inst_mem_r[head_r];

    // Fetch PC: load on redirect, otherwise advance one word per accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
        end
    end

    // Response PC: the tag for the next response that is kept (not discarded).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            resp_pc_r <= redirect_tgt_s;
        end else if (push_s) begin
            resp_pc_r <= resp_pc_r + 32'd4;
        end
    end

    // Count of requests accepted by imem whose response has not yet returned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_r <= CNT_ZERO_C;
        end else begin
            case ({req_fire_s, resp_fire_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_ONE_C;
                2'b01:   outstanding_r <= outstanding_r - CNT_ONE_C;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // On a redirect, every response still in flight becomes stale, including any left from an earlier redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_r <= CNT_ZERO_C;
        end else if (redirect_valid) begin
            drop_cnt_r <= outstanding_r - resp_fire_ext_s;
        end else if (drop_s) begin
            drop_cnt_r <= drop_cnt_r - CNT_ONE_C;
        end
    end

    // Fetch-queue pointers and occupancy; a redirect empties the queue and ignores any pop in that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r     <= PTR_ZERO_C;
            tail_r     <= PTR_ZERO_C;
            fq_count_r <= CNT_ZERO_C;
        end else if (redirect_valid) begin
            head_r     <= PTR_ZERO_C;
            tail_r     <= PTR_ZERO_C;
            fq_count_r <= CNT_ZERO_C;
        end else begin
            if (push_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push_s, pop_s})
                2'b10:   fq_count_r <= fq_count_r + CNT_ONE_C;
                2'b01:   fq_count_r <= fq_count_r - CNT_ONE_C;
                default: fq_count_r <= fq_count_r;
            endcase
        end
    end

    // Fetch-queue storage; reset clears it so the outputs read zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem_r[i]   <= 32'h0000_0000;
                inst_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[tail_r]   <= resp_pc_r;
            inst_mem_r[tail_r] <= imem_resp_inst;
        end
    end

`ifdef IFETCH_STATS_EN
    logic [31:0] stat_drop_r;

    // Free-running count of discarded responses; wraps at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_drop_r <= 32'h0000_0000;
        end else if (drop_s) begin
            stat_drop_r <= stat_drop_r + 32'd1;
        end
    end

    assign stat_drop_cnt = stat_drop_r;
`endif

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch initiator that drives the `imem` request/response port and feeds a small fetch queue toward decode. It owns the fetch PC, issues sequential word fetches under a credit limit, and tags each returned instruction with its PC. On a redirect from the back end it discards every in-flight response without stalling the memory protocol. It sits between the branch/redirect logic and `imem` on one side, and the decode stage on the other.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.
- `MAX_OUTSTANDING`, 4: maximum number of requests accepted by `imem` whose response has not yet arrived.
- `FQ_DEPTH`, 4: number of fetch-queue entries; must be ≥ 2.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `redirect_valid`  in  1  one-cycle redirect strobe from the back end.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  `imem` can accept a request.
- `imem_req_addr`  out  32  byte address of the fetch, word-aligned.
- `imem_resp_valid`  in  1  `imem` response valid; responses return in order.
- `imem_resp_ready`  out  1  response accept; constant 1 outside reset.
- `imem_resp_inst`  in  32  fetched instruction word.
- `out_valid`  out  1  fetch-queue head valid.
- `out_ready`  in  1  decode accepts the head.
- `out_pc`  out  32  PC of the head instruction.
- `out_inst`  out  32  head instruction word.

## Operation
**Counters**
- `fetch_pc`: address of the next request.
- `resp_pc`: PC of the next non-stale response.
- `outstanding`: 0..`MAX_OUTSTANDING`.
- `drop_cnt`: 0..`MAX_OUTSTANDING`.
- `fq_count`: 0..`FQ_DEPTH`.

**Issue**
- `imem_req_valid` = !`redirect_valid` && `outstanding` < `MAX_OUTSTANDING` && (`outstanding` + `fq_count`) < `FQ_DEPTH`.
- `imem_req_addr` = `fetch_pc`.
- `imem_req_valid` may drop without a handshake; `imem` does not depend on valid persistence.
- On a request handshake, `fetch_pc` += 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).

**Response**
- The credit check guarantees a fetch-queue slot for every in-flight response, so `imem_resp_ready` is tied to 1.
- If `drop_cnt` > 0, the response is discarded and `drop_cnt` decrements.
- Otherwise {`resp_pc`, `imem_resp_inst`} is pushed into the queue and `resp_pc` += 4 (wrapping).

**Outstanding update**
- +1 on a request handshake, −1 on a response handshake; both in one cycle leaves it unchanged.

**Redirect** (`redirect_valid` = 1)
- `fetch_pc` and `resp_pc` take `{redirect_pc[31:2], 2'b00}`.
- The fetch queue is flushed; `fq_count` = 0 and any `out_ready` pop that cycle is ignored.
- `drop_cnt` takes (`outstanding` − response-fire this cycle). This holds even if `drop_cnt` was already nonzero.
- A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins.

**Fetch queue**
- Circular FIFO with head and tail pointers that wrap at `FQ_DEPTH`.
- Push and pop in the same cycle keep `fq_count` unchanged.

## Timing
- **Reset values** (`rst_n` = 0 sampled):
  - `fetch_pc` = `resp_pc` = `RESET_PC`.
  - All counters 0.
  - `out_valid` = 0, `out_pc` = 0, `out_inst` = 0.
  - `imem_req_valid` is forced 0 while `rst_n` is low.
  - `imem_resp_ready` = 1.
- **First request:** in the first cycle after `rst_n` rises, `imem_req_valid` = 1 with address `RESET_PC`.
- **Response to output:** a response accepted in cycle N is visible on `out_*` in cycle N+1. There is no bypass path.
- **Throughput:** sustains 1 instruction/cycle with 1-cycle `imem` latency and `out_ready` held at 1.
- **Redirect to first new request:** redirect in cycle N gives the first request at the new PC in cycle N+1.
- **Reset mid-operation:** all in-flight state is lost. The `imem` side is reset by the same `rst_n`.

## Configuration
- `IFETCH_STATS_EN` defined:
  - Adds output `stat_drop_cnt` (32 bits), reset to 0.
  - Increments by 1 per discarded response and wraps at 2^32.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Reset and sequential fetch:** reset with `RESET_PC`=0x100, `out_ready`=1, 1-cycle `imem` → requests at 0x100, 0x104, 0x108, … one per cycle; `out_pc` in the same order starting 2 cycles after the first request.
- **Back-pressure:** hold `out_ready`=0 → at most `FQ_DEPTH`(4) requests issued, `fq_count`=4, `imem_req_valid`=0. Release → drains 4 entries in order, then fetching resumes.
- **Redirect with in-flight requests:** 3 outstanding, redirect to 0x2003 → those 3 responses never appear on `out`; next `out_pc`=0x2000.
- **Simultaneous events:** redirect coinciding with a response and with an `out` pop → response dropped, queue empty, `drop_cnt` = `outstanding` − 1.
- **PC wrap:** `redirect_pc`=0xFFFF_FFF8 → `out_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Statistics (`IFETCH_STATS_EN`):** after the in-flight redirect scenario, `stat_drop_cnt`=3.
